seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_scan_driver_decode.sv | 39 +++
 rtl/seg7_scan_driver.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the 7-segment scan driver.
//   - SEG_* : logical (active-high) segment patterns {a,b,c,d,e,f,g} for
//             hex codes 0..F, plus SEG_OFF for a dark digit.
//   - cnt_width() : counter width helper, never returns less than 1 bit.
package seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_A   = 7'b1110111;
    localparam logic [6:0] SEG_B   = 7'b0011111;
    localparam logic [6:0] SEG_C   = 7'b1001110;
    localparam logic [6:0] SEG_D   = 7'b0111101;
    localparam logic [6:0] SEG_E   = 7'b1001111;
    localparam logic [6:0] SEG_F   = 7'b1000111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Width of a counter covering 0..n-1; a single state still needs one bit.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// seg7_decode
// Combinational 4-bit code to 7-segment logical pattern decoder.
// Ports:
//   code    in  [3:0] digit code
//   hex_en  in        1 = codes 10..15 show A,b,C,d,E,F; 0 = blank
//   pattern out [6:0] logical segments {a..g}, 1 = lit (no polarity applied)
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_en,
    output logic [6:0] pattern
);

    // Code lookup; letters are gated by hex_en so a BCD-only readout stays dark.
    always_comb begin
        pattern = SEG_OFF;
        case (code)
            4'h0:    pattern = SEG_0;
            4'h1:    pattern = SEG_1;
            4'h2:    pattern = SEG_2;
            4'h3:    pattern = SEG_3;
            4'h4:    pattern = SEG_4;
            4'h5:    pattern = SEG_5;
            4'h6:    pattern = SEG_6;
            4'h7:    pattern = SEG_7;
            4'h8:    pattern = SEG_8;
            4'h9:    pattern = SEG_9;
            4'hA:    pattern = hex_en ? SEG_A : SEG_OFF;
            4'hB:    pattern = hex_en ? SEG_B : SEG_OFF;
            4'hC:    pattern = hex_en ? SEG_C : SEG_OFF;
            4'hD:    pattern = hex_en ? SEG_D : SEG_OFF;
            4'hE:    pattern = hex_en ? SEG_E : SEG_OFF;
            4'hF:    pattern = hex_en ? SEG_F : SEG_OFF;
            default: pattern = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a DIGITS-wide 7-segment display. Each digit
// owns a SCAN_DIV-cycle slot whose first DEAD_CYC cycles keep every anode
// dark (anti-ghosting). Inputs are snapshotted at frame start so a display
// update never tears mid-scan. All outputs are registered.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              scan enable (0 = hold position, outputs dark)
//   digits_in       4 bits per digit, digit 0 rightmost at [3:0]
//   blank_in        per-digit force-dark mask
//   dp_in           per-digit decimal point mask
//   seg, dp         segment outputs {a..g} and decimal point, polarity applied
//   an              one-hot digit select, polarity applied
//   frame_done      one-cycle pulse after the last digit's slot ends
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 6,
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYC    = 16,
    parameter int HEX_EN      = 0,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int PW = cnt_width(SCAN_DIV);
    localparam int IW = cnt_width(DIGITS);

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRESC_DEAD = PW'(DEAD_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    // XOR masks turn a logical "on" pattern into the pin level.
    localparam logic [6:0]        SEG_POL = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_POL  = (SEG_ACT_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [DIGITS-1:0] AN_POL  = (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic              HEX_ON  = (HEX_EN != 0) ? 1'b1 : 1'b0;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   snap_dig_q, snap_dig_d;
    logic [DIGITS-1:0]     snap_blank_q, snap_blank_d;
    logic [DIGITS-1:0]     snap_dp_q, snap_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  capture_s;
    logic [4*DIGITS-1:0]   eff_dig_s;
    logic [DIGITS-1:0]     eff_blank_s;
    logic [DIGITS-1:0]     eff_dp_s;
    logic [3:0]            code_s;
    logic [6:0]            pattern_s;
    logic [DIGITS-1:0]     an_onehot_s;

    // Frame start is prescaler==0 and idx==0; reset leaves the counters
    // there, so the first enabled cycle after reset is also a capture.
    // The capture cycle decodes straight from the inputs so that with
    // DEAD_CYC=0 the first slot never shows stale data for one cycle.
    always_comb begin
        capture_s   = en && (presc_q == {PW{1'b0}}) && (idx_q == {IW{1'b0}});
        eff_dig_s   = capture_s ? digits_in : snap_dig_q;
        eff_blank_s = capture_s ? blank_in  : snap_blank_q;
        eff_dp_s    = capture_s ? dp_in     : snap_dp_q;
        code_s      = eff_dig_s[4*idx_q +: 4];
        an_onehot_s = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
    end

    seg7_decode u_decode (
        .code    (code_s),
        .hex_en  (HEX_ON),
        .pattern (pattern_s)
    );

    // Next-state: prescaler/index advance, snapshot, and the output image.
    always_comb begin
        presc_d      = presc_q;
        idx_d        = idx_q;
        snap_dig_d   = snap_dig_q;
        snap_blank_d = snap_blank_q;
        snap_dp_d    = snap_dp_q;
        an_d         = AN_POL;
        seg_d        = SEG_OFF ^ SEG_POL;
        dp_d         = 1'b0 ^ DP_POL;
        frame_done_d = 1'b0;
        if (en) begin
            if (capture_s) begin
                snap_dig_d   = digits_in;
                snap_blank_d = blank_in;
                snap_dp_d    = dp_in;
            end else begin
                snap_dig_d   = snap_dig_q;
            end
            if (presc_q == PRESC_LAST) begin
                presc_d      = {PW{1'b0}};
                idx_d        = (idx_q == IDX_LAST) ? {IW{1'b0}} : idx_q + 1'b1;
                frame_done_d = (idx_q == IDX_LAST);
            end else begin
                presc_d      = presc_q + 1'b1;
            end
            // Past the dead time the digit is selected even when blanked,
            // keeping the duty cycle uniform; only its segments go dark.
            if (presc_q >= PRESC_DEAD) begin
                an_d = an_onehot_s ^ AN_POL;
                if (!eff_blank_s[idx_q]) begin
                    seg_d = pattern_s ^ SEG_POL;
                    dp_d  = eff_dp_s[idx_q] ^ DP_POL;
                end else begin
                    seg_d = SEG_OFF ^ SEG_POL;
                end
            end else begin
                an_d = AN_POL;
            end
        end else begin
            // Disabled: position held, outputs left at their dark defaults.
            presc_d = presc_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= {PW{1'b0}};
            idx_q        <= {IW{1'b0}};
            snap_dig_q   <= {(4*DIGITS){1'b0}};
            snap_blank_q <= {DIGITS{1'b0}};
            snap_dp_q    <= {DIGITS{1'b0}};
            an_q         <= AN_POL;
            seg_q        <= SEG_OFF ^ SEG_POL;
            dp_q         <= DP_POL;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            snap_dig_q   <= snap_dig_d;
            snap_blank_q <= snap_blank_d;
            snap_dp_q    <= snap_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Self-checking bench: two instances (HEX_EN=0 and HEX_EN=1) share the same
// stimulus; a reference model counts enabled cycles within a frame and
// derives slot, dead time, digit and segment values from that count.
module tb_seg7_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEAD_CYC = 1;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] digits_in;
    logic [3:0]  blank_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  an0, an1;
    logic        fd0, fd1;

    int n_vec;
    int n_err;

    // Reference state: position within the frame and the frame snapshot.
    int          m_pos;
    logic [15:0] m_dig;
    logic [3:0]  m_blank;
    logic [3:0]  m_dp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg0, e_seg1;
    logic        e_dp, e_fd;

    // Logical segment patterns a..g for codes 0..F, straight from the display table.
    logic [6:0] font [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD_CYC(DEAD_CYC),
        .HEX_EN(0), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
    ) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .digits_in(digits_in),
        .blank_in(blank_in), .dp_in(dp_in), .seg(seg0), .dp(dp0),
        .an(an0), .frame_done(fd0)
    );

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD_CYC(DEAD_CYC),
        .HEX_EN(1), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .digits_in(digits_in),
        .blank_in(blank_in), .dp_in(dp_in), .seg(seg1), .dp(dp1),
        .an(an1), .frame_done(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Pin levels (active low) for a digit code, blank codes dark in BCD mode.
    function automatic logic [6:0] ref_seg(input logic [3:0] c, input bit hex, input bit blank);
        logic [6:0] p;
        p = font[c];
        if (blank || (!hex && c > 4'd9)) begin
            p = 7'b0000000;
        end
        return ~p;
    endfunction

    // Advance the model across one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        int slot;
        int d;
        e_an   = 4'b1111;
        e_seg0 = 7'b1111111;
        e_seg1 = 7'b1111111;
        e_dp   = 1'b1;
        e_fd   = 1'b0;
        if (rst) begin
            m_pos   = 0;
            m_dig   = 16'h0000;
            m_blank = 4'b0000;
            m_dp    = 4'b0000;
        end else if (en) begin
            if (m_pos == 0) begin
                m_dig   = digits_in;
                m_blank = blank_in;
                m_dp    = dp_in;
            end
            slot = m_pos % SCAN_DIV;
            d    = m_pos / SCAN_DIV;
            if (slot >= DEAD_CYC) begin
                e_an   = ~(4'b0001 << d);
                e_seg0 = ref_seg(m_dig[4*d +: 4], 1'b0, m_blank[d]);
                e_seg1 = ref_seg(m_dig[4*d +: 4], 1'b1, m_blank[d]);
                e_dp   = ~(m_dp[d] & ~m_blank[d]);
            end
            e_fd  = (m_pos == FRAME - 1);
            m_pos = (m_pos + 1) % FRAME;
        end
    endtask

    // One clock: update the model at the edge, compare both DUTs just after it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("an_bcd",  {12'h000, an0},  {12'h000, e_an});
        check_val("seg_bcd", {9'h000, seg0},  {9'h000, e_seg0});
        check_val("dp_bcd",  {15'h0000, dp0}, {15'h0000, e_dp});
        check_val("fd_bcd",  {15'h0000, fd0}, {15'h0000, e_fd});
        check_val("an_hex",  {12'h000, an1},  {12'h000, e_an});
        check_val("seg_hex", {9'h000, seg1},  {9'h000, e_seg1});
        check_val("dp_hex",  {15'h0000, dp1}, {15'h0000, e_dp});
        check_val("fd_hex",  {15'h0000, fd1}, {15'h0000, e_fd});
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_pos     = 0;
        m_dig     = 16'h0000;
        m_blank   = 4'b0000;
        m_dp      = 4'b0000;
        rst       = 1'b1;
        en        = 1'b0;
        digits_in = 16'h4321;
        blank_in  = 4'b0000;
        dp_in     = 4'b0000;

        // Reset held for three cycles, then scan 4321.
        run(3);
        check_val("rst_an", {12'h000, an0}, 16'h000F);
        check_val("rst_seg", {9'h000, seg0}, 16'h007F);
        rst = 1'b0;
        en  = 1'b1;
        run(2);
        check_val("first_sel", {12'h000, an0}, 16'h000E);
        check_val("first_seg", {9'h000, seg0}, 16'h004F);
        run(38);

        // Mid-frame update during digit 1's slot.
        for (int i = 0; i < FRAME && m_pos != SCAN_DIV + 2; i++) begin
            step();
        end
        digits_in = 16'h9999;
        run(36);

        // Blank digit 3, light dp on digit 1.
        blank_in = 4'b1000;
        dp_in    = 4'b0010;
        run(36);

        // Hex codes on both decoder modes.
        blank_in  = 4'b0000;
        dp_in     = 4'b0000;
        digits_in = 16'hFA0B;
        run(36);

        // Drop en for five cycles inside digit 2's slot.
        for (int i = 0; i < FRAME && m_pos != 2 * SCAN_DIV + 2; i++) begin
            step();
        end
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(12);

        // Reset mid-slot, then resume.
        for (int i = 0; i < FRAME && m_pos != SCAN_DIV + 2; i++) begin
            step();
        end
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(20);

        // Randomized traffic: data/mask changes, enable gaps, occasional reset.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) digits_in = 16'($urandom);
            if ($urandom_range(0, 9) == 0) blank_in  = 4'($urandom);
            if ($urandom_range(0, 9) == 0) dp_in     = 4'($urandom);
            en  = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
